// File: rtl/calc_entry_sequencer.sv
// Calculator entry sequencer: builds operands from keypad digits, runs the ALU, drives display/status. Optional CALC_CHAIN_EN chains from a shown result.
// Latency: eq_valid at edge N -> alu_start in cycle N+1; alu_done at edge M -> result displayed in cycle M+1.
// Backpressure: none; keys arriving in EXEC/WAIT (other than clr) are dropped, ALU timeout bounds the wait.
module calc_entry_sequencer #(
    parameter int WIDTH       = 16,
    parameter int MAX_DIGITS  = 4,
    parameter int ALU_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             digit_valid,
    input  logic [3:0]       digit,
    input  logic             op_valid,
    input  logic [1:0]       op,
    input  logic             eq_valid,
    input  logic             clr,
    output logic             alu_start,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_op,
    input  logic             alu_done,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_err,
    output logic [WIDTH-1:0] disp_value,
    output logic             busy,
    output logic             error
);

    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam int TW = $clog2(ALU_TIMEOUT + 1);

    typedef enum logic [2:0] {
        ENTER_A,
        ENTER_B,
        EXEC,
        WAIT,
        SHOW,
        ERR
    } state_t;

    state_t          state, state_nx;
    logic [WIDTH-1:0] a, a_nx;
    logic [WIDTH-1:0] b, b_nx;
    logic [WIDTH-1:0] r, r_nx;
    logic [1:0]       op_q, op_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [TW-1:0]    tmo, tmo_nx;

    logic             digit_ok;
    logic             cnt_full;
    logic [WIDTH-1:0] acc_src;
    logic [WIDTH-1:0] acc_new;
    logic [WIDTH-1:0] digit_ext;

    assign digit_ok  = (digit <= 4'd9);
    assign cnt_full  = (cnt >= CW'(MAX_DIGITS));
    assign digit_ext = {{(WIDTH-4){1'b0}}, digit};
    assign acc_src   = (state == ENTER_B) ? b : a;
    // acc*10 as shift-add; wraps mod 2^WIDTH
    assign acc_new   = (acc_src << 3) + (acc_src << 1) + digit_ext;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ENTER_A;
            a     <= '0;
            b     <= '0;
            r     <= '0;
            op_q  <= 2'b00;
            cnt   <= '0;
            tmo   <= '0;
        end else begin
            state <= state_nx;
            a     <= a_nx;
            b     <= b_nx;
            r     <= r_nx;
            op_q  <= op_nx;
            cnt   <= cnt_nx;
            tmo   <= tmo_nx;
        end
    end

    always_comb begin
        state_nx = state;
        a_nx     = a;
        b_nx     = b;
        r_nx     = r;
        op_nx    = op_q;
        cnt_nx   = cnt;
        tmo_nx   = tmo;

        if (clr) begin
            state_nx = ENTER_A;
            a_nx     = '0;
            b_nx     = '0;
            r_nx     = '0;
            op_nx    = 2'b00;
            cnt_nx   = '0;
            tmo_nx   = '0;
        end else begin
            case (state)
                ENTER_A: begin
                    // eq wins priority here but has no effect
                    if (eq_valid) begin
                    end else if (op_valid) begin
                        op_nx    = op;
                        b_nx     = '0;
                        cnt_nx   = '0;
                        state_nx = ENTER_B;
                    end else if (digit_valid && digit_ok && !cnt_full) begin
                        a_nx   = acc_new;
                        cnt_nx = cnt + CW'(1);
                    end
                end
                ENTER_B: begin
                    if (eq_valid) begin
                        state_nx = EXEC;
                    end else if (op_valid) begin
                        op_nx = op;
                    end else if (digit_valid && digit_ok && !cnt_full) begin
                        b_nx   = acc_new;
                        cnt_nx = cnt + CW'(1);
                    end
                end
                EXEC: begin
                    // the start cycle counts as the first timeout cycle
                    tmo_nx   = TW'(1);
                    state_nx = WAIT;
                end
                WAIT: begin
                    if (alu_done) begin
                        if (alu_err) begin
                            state_nx = ERR;
                        end else begin
                            r_nx     = alu_result;
                            state_nx = SHOW;
                        end
                    end else if (tmo >= TW'(ALU_TIMEOUT - 1)) begin
                        state_nx = ERR;
                    end else begin
                        tmo_nx = tmo + TW'(1);
                    end
                end
                SHOW: begin
                    if (eq_valid) begin
                    end else if (op_valid) begin
`ifdef CALC_CHAIN_EN
                        a_nx     = r;
                        op_nx    = op;
                        b_nx     = '0;
                        cnt_nx   = '0;
                        state_nx = ENTER_B;
`endif
                    end else if (digit_valid && digit_ok) begin
                        a_nx     = digit_ext;
                        cnt_nx   = CW'(1);
                        state_nx = ENTER_A;
                    end
                end
                ERR: begin
                end
                default: begin
                    state_nx = ENTER_A;
                end
            endcase
        end
    end

    assign alu_start = (state == EXEC);
    assign busy      = (state == EXEC) || (state == WAIT);
    assign error     = (state == ERR);
    assign alu_a     = a;
    assign alu_b     = b;
    assign alu_op    = op_q;

    always_comb begin
        disp_value = '0;
        case (state)
            ENTER_A: disp_value = a;
            ENTER_B: disp_value = b;
            EXEC:    disp_value = b;
            WAIT:    disp_value = b;
            SHOW:    disp_value = r;
            default: disp_value = '0;
        endcase
    end

endmodule

// File: tb/tb_calc_entry_sequencer.sv
// Bench for calc_entry_sequencer: key-level reference model, ALU operand scoreboard, directed and random key sequences.
module tb_calc_entry_sequencer;

    localparam int WIDTH       = 16;
    localparam int MAX_DIGITS  = 4;
    localparam int ALU_TIMEOUT = 255;
    localparam longint MODV    = 64'd1 << WIDTH;

    logic             clk = 1'b0;
    logic             reset;
    logic             digit_valid;
    logic [3:0]       digit;
    logic             op_valid;
    logic [1:0]       op;
    logic             eq_valid;
    logic             clr;
    logic             alu_start;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [1:0]       alu_op;
    logic             alu_done;
    logic [WIDTH-1:0] alu_result;
    logic             alu_err;
    logic [WIDTH-1:0] disp_value;
    logic             busy;
    logic             error;

    always #5 clk = ~clk;

    calc_entry_sequencer #(
        .WIDTH(WIDTH),
        .MAX_DIGITS(MAX_DIGITS),
        .ALU_TIMEOUT(ALU_TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .digit_valid(digit_valid),
        .digit(digit),
        .op_valid(op_valid),
        .op(op),
        .eq_valid(eq_valid),
        .clr(clr),
        .alu_start(alu_start),
        .alu_a(alu_a),
        .alu_b(alu_b),
        .alu_op(alu_op),
        .alu_done(alu_done),
        .alu_result(alu_result),
        .alu_err(alu_err),
        .disp_value(disp_value),
        .busy(busy),
        .error(error)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model, advanced one key press at a time.
    typedef enum int {M_A, M_B, M_BUSY, M_SHOW, M_ERR} mph_t;
    typedef struct {
        int a;
        int b;
        int op;
    } xact_t;

    mph_t  ph;
    int    ma, mb, mop, mr, mcnt;
    xact_t exp_q[$];

    task automatic model_clear();
        ph = M_A; ma = 0; mb = 0; mop = 0; mr = 0; mcnt = 0;
    endtask

    task automatic model_key(input bit dv, input int d, input bit ov, input int o,
                             input bit ev, input bit cv);
        xact_t x;
        if (cv) begin
            model_clear();
        end else if (ev) begin
            if (ph == M_B) begin
                x.a = ma; x.b = mb; x.op = mop;
                exp_q.push_back(x);
                ph = M_BUSY;
            end
        end else if (ov) begin
            if (ph == M_A) begin
                mop = o; mb = 0; mcnt = 0; ph = M_B;
            end else if (ph == M_B) begin
                mop = o;
            end else if (ph == M_SHOW) begin
`ifdef CALC_CHAIN_EN
                ma = mr; mop = o; mb = 0; mcnt = 0; ph = M_B;
`endif
            end
        end else if (dv && d <= 9) begin
            if (ph == M_A && mcnt < MAX_DIGITS) begin
                ma = int'((longint'(ma) * 10 + d) % MODV); mcnt++;
            end else if (ph == M_B && mcnt < MAX_DIGITS) begin
                mb = int'((longint'(mb) * 10 + d) % MODV); mcnt++;
            end else if (ph == M_SHOW) begin
                ma = d; mcnt = 1; ph = M_A;
            end
        end
    endtask

    function automatic int model_disp();
        case (ph)
            M_A:    return ma;
            M_B:    return mb;
            M_SHOW: return mr;
            default: return 0;
        endcase
    endfunction

    task automatic alu_ref(input int a, input int b, input int o, output int res, output bit err);
        err = 1'b0;
        res = 0;
        case (o)
            0: res = int'((longint'(a) + b) % MODV);
            1: res = int'((longint'(a) - b + MODV) % MODV);
            2: res = int'((longint'(a) * b) % MODV);
            default: begin
                if (b == 0) err = 1'b1;
                else res = a / b;
            end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input bit dv, input int d, input bit ov, input int o,
                         input bit ev, input bit cv);
        digit_valid = dv;
        digit       = d[3:0];
        op_valid    = ov;
        op          = o[1:0];
        eq_valid    = ev;
        clr         = cv;
        model_key(dv, d, ov, o, ev, cv);
        tick();
        digit_valid = 1'b0;
        op_valid    = 1'b0;
        eq_valid    = 1'b0;
        clr         = 1'b0;
    endtask

    task automatic check_outputs(input string name);
        chk({name, "_disp"}, int'(disp_value), model_disp());
        chk({name, "_error"}, int'(error), int'(ph == M_ERR));
        chk({name, "_busy"}, int'(busy), 0);
        chk({name, "_start"}, int'(alu_start), 0);
    endtask

    // Called in the EXEC cycle; asserts alu_done during the lat-th WAIT cycle.
    task automatic run_alu(input int lat);
        int res;
        bit err;
        int busy_n;
        int start_n;
        alu_ref(ma, mb, mop, res, err);
        busy_n  = 0;
        start_n = 0;
        for (int i = 0; i <= lat; i++) begin
            if (busy) busy_n++;
            if (alu_start) start_n++;
            if (i == lat) begin
                alu_done   = 1'b1;
                alu_result = res[WIDTH-1:0];
                alu_err    = err;
            end
            tick();
        end
        alu_done   = 1'b0;
        alu_err    = 1'b0;
        alu_result = WIDTH'($urandom);
        chk("busy_cycles", busy_n, lat + 1);
        chk("start_pulses", start_n, 1);
        if (err) ph = M_ERR;
        else begin
            mr = res;
            ph = M_SHOW;
        end
        check_outputs("after_alu");
    endtask

    // Scoreboard: operands at alu_start and while the ALU completes.
    xact_t cur;
    always @(negedge clk) begin
        if (!reset) begin
            if (alu_start) begin
                chk("start_has_expect", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    cur = exp_q.pop_front();
                    chk("start_alu_a", int'(alu_a), cur.a);
                    chk("start_alu_b", int'(alu_b), cur.b);
                    chk("start_alu_op", int'(alu_op), cur.op);
                end
            end
            if (alu_done && busy) begin
                chk("hold_alu_a", int'(alu_a), cur.a);
                chk("hold_alu_b", int'(alu_b), cur.b);
                chk("hold_alu_op", int'(alu_op), cur.op);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        int d;
        int o;
        bit dv, ov, ev, cv;

        reset = 1'b1;
        digit_valid = 1'b0; digit = 4'd0; op_valid = 1'b0; op = 2'd0;
        eq_valid = 1'b0; clr = 1'b0;
        alu_done = 1'b0; alu_result = '0; alu_err = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick();

        check_outputs("reset");
        chk("reset_alu_a", int'(alu_a), 0);
        chk("reset_alu_b", int'(alu_b), 0);
        chk("reset_alu_op", int'(alu_op), 0);

        // 12 + 3 with a 5-cycle ALU
        press(1, 1, 0, 0, 0, 0);
        press(1, 2, 0, 0, 0, 0);
        chk("t1_disp_a", int'(disp_value), 12);
        press(0, 0, 1, 0, 0, 0);
        press(1, 3, 0, 0, 0, 0);
        chk("t1_disp_b", int'(disp_value), 3);
        press(0, 0, 0, 0, 1, 0);
        chk("t1_start", int'(alu_start), 1);
        run_alu(5);
        chk("t1_result", int'(disp_value), 15);

        // Operator in SHOW: chains when enabled, ignored otherwise
        press(0, 0, 1, 1, 0, 0);
        check_outputs("chain_op");
        press(1, 5, 0, 0, 0, 0);
        check_outputs("chain_digit");
`ifndef CALC_CHAIN_EN
        chk("nochain_new_a", int'(disp_value), 5);
`endif
        press(0, 0, 0, 0, 1, 0);
        if (ph == M_BUSY) run_alu(3);
        else check_outputs("chain_eq");
`ifdef CALC_CHAIN_EN
        chk("chain_result", int'(disp_value), 10);
`endif

        // Digit limit and invalid digit
        press(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) press(1, 9, 0, 0, 0, 0);
        chk("max_digits", int'(disp_value), 9999);
        press(1, 12, 0, 0, 0, 0);
        chk("bad_digit", int'(disp_value), 9999);

        // Divide by zero -> ERR, clr recovers
        press(0, 0, 0, 0, 0, 1);
        press(1, 5, 0, 0, 0, 0);
        press(0, 0, 1, 3, 0, 0);
        press(0, 0, 0, 0, 1, 0);
        run_alu(4);
        chk("div0_error", int'(error), 1);
        chk("div0_disp", int'(disp_value), 0);
        press(1, 4, 1, 1, 1, 0);
        chk("err_sticky", int'(error), 1);
        press(0, 0, 0, 0, 0, 1);
        check_outputs("err_clr");

        // ALU never answers -> timeout
        press(1, 8, 0, 0, 0, 0);
        press(0, 0, 1, 0, 0, 0);
        press(0, 0, 0, 0, 1, 0);
        n = 0;
        for (int i = 1; i <= ALU_TIMEOUT + 10; i++) begin
            tick();
            if (error) begin
                n = i;
                break;
            end
        end
        chk("timeout_cycles", n, ALU_TIMEOUT);
        ph = M_ERR;
        check_outputs("timeout");
        press(0, 0, 0, 0, 0, 1);

        // clr mid-WAIT, then a stray alu_done
        press(1, 6, 0, 0, 0, 0);
        press(0, 0, 1, 2, 0, 0);
        press(1, 7, 0, 0, 0, 0);
        press(0, 0, 0, 0, 1, 0);
        repeat (3) tick();
        press(0, 0, 0, 0, 0, 1);
        alu_done = 1'b1; alu_result = 16'd1234; alu_err = 1'b0;
        tick();
        alu_done = 1'b0;
        check_outputs("stray_done");
        press(1, 7, 0, 0, 0, 0);
        chk("stray_enter_a", int'(disp_value), 7);

        // eq beats digit in ENTER_B; clr beats op
        press(0, 0, 0, 0, 0, 1);
        press(1, 4, 0, 0, 0, 0);
        press(0, 0, 1, 2, 0, 0);
        press(1, 2, 0, 0, 0, 0);
        press(1, 7, 0, 0, 1, 0);
        chk("eq_wins_busy", int'(busy), 1);
        run_alu(2);
        chk("eq_wins_result", int'(disp_value), 8);
        press(1, 3, 0, 0, 0, 0);
        press(0, 0, 1, 2, 0, 1);
        check_outputs("clr_wins");
        chk("clr_wins_op", int'(alu_op), 0);
        press(1, 1, 0, 0, 0, 0);
        chk("clr_wins_enter_a", int'(disp_value), 1);

        // Random key streams against the model
        for (int t = 0; t < 400; t++) begin
            k  = $urandom_range(0, 15);
            d  = $urandom_range(0, 11);
            o  = $urandom_range(0, 3);
            dv = 1'b0; ov = 1'b0; ev = 1'b0; cv = 1'b0;
            if (ph == M_ERR && $urandom_range(0, 3) == 0) cv = 1'b1;
            else if (k < 8) dv = 1'b1;
            else if (k < 11) ov = 1'b1;
            else if (k < 13) ev = 1'b1;
            else if (k == 13) cv = 1'b1;
            else begin
                dv = 1'b1;
                ov = 1'($urandom_range(0, 1));
                ev = 1'($urandom_range(0, 1));
            end
            press(dv, d, ov, o, ev, cv);
            if (ph == M_BUSY) run_alu($urandom_range(1, 12));
            else check_outputs("rand");
        end

        tick();
        chk("expect_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
